// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control unit and its datapath.
// Carries the decoded instruction fields, the memory handshake, the
// control strobes and selects, and the status outputs of the FSM.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             PCWE;
    logic             IRWE;
    logic             RFWE;
    logic             DMWE;
    logic             IorD;
    logic             M_to_RF_sel;
    logic             RFD_sel;
    logic [1:0]       ALU_in_sel1;
    logic [1:0]       ALU_in_sel2;
    logic [1:0]       PC_src;
    logic [3:0]       ALU_sel;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    // Control unit side: consumes instruction fields, drives the controls.
    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCWE, IRWE, RFWE, DMWE, IorD, M_to_RF_sel, RFD_sel,
               ALU_in_sel1, ALU_in_sel2, PC_src, ALU_sel,
               state, illegal, instr_count
    );

    // Datapath side: supplies instruction fields, obeys the controls.
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWE, IRWE, RFWE, DMWE, IorD, M_to_RF_sel, RFD_sel,
               ALU_in_sel1, ALU_in_sel2, PC_src, ALU_sel,
               state, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit (LW, SW, R-type, BEQ, ADDI, J).
// Moore-style FSM: the state is registered, controls decode combinationally
// from the state plus instruction fields and the memory handshake.
// Write strobes and the illegal pulse are suppressed while reset is high so
// an instruction interrupted by reset cannot commit anything.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;

    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_REGA   = 2'b01;
    localparam logic [1:0] A_SHAMT  = 2'b10;
    localparam logic [1:0] B_REGB   = 2'b00;
    localparam logic [1:0] B_FOUR   = 2'b01;
    localparam logic [1:0] B_IMM    = 2'b10;
    localparam logic [1:0] B_IMMSH  = 2'b11;
    localparam logic [1:0] PC_ALU   = 2'b00;
    localparam logic [1:0] PC_OUT   = 2'b01;
    localparam logic [1:0] PC_JUMP  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_s;
    logic [CNT_W-1:0] count_r;
    logic [3:0]       alu_hold_r;
    logic [3:0]       alu_hold_s;
    logic             retire_s;

    logic             pcwe_s;
    logic             irwe_s;
    logic             rfwe_s;
    logic             dmwe_s;
    logic             iord_s;
    logic             m_to_rf_s;
    logic             rfd_s;
    logic [1:0]       sel1_s;
    logic [1:0]       sel2_s;
    logic [1:0]       pc_src_s;
    logic [3:0]       alu_sel_s;
    logic             illegal_s;

    // Next-state and control decode from the current state and inputs.
    always_comb begin
        next_s     = S_FETCH;
        retire_s   = 1'b0;
        alu_hold_s = alu_hold_r;
        pcwe_s     = 1'b0;
        irwe_s     = 1'b0;
        rfwe_s     = 1'b0;
        dmwe_s     = 1'b0;
        iord_s     = 1'b0;
        m_to_rf_s  = 1'b0;
        rfd_s      = 1'b0;
        sel1_s     = A_PC;
        sel2_s     = B_REGB;
        pc_src_s   = PC_ALU;
        alu_sel_s  = 4'b0000;
        illegal_s  = 1'b0;

        case (state_r)
            S_FETCH: begin
                sel2_s    = B_FOUR;
                alu_sel_s = ALU_ADD;
                irwe_s    = bus.mem_ready;
                pcwe_s    = bus.mem_ready;
                if (bus.mem_ready) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while decoding
                sel2_s    = B_IMMSH;
                alu_sel_s = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: next_s = S_MEM_ADDR;
                    OP_RTYPE:     next_s = S_R_EXEC;
                    OP_BEQ:       next_s = S_BRANCH;
                    OP_ADDI:      next_s = S_ADDI_EXEC;
                    OP_J:         next_s = S_JUMP;
                    default: begin
                        illegal_s = 1'b1;
                        next_s    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                sel1_s    = A_REGA;
                sel2_s    = B_IMM;
                alu_sel_s = ALU_ADD;
                if (bus.opcode == OP_SW) begin
                    next_s = S_MEM_WR;
                end else if (bus.opcode == OP_LW) begin
                    next_s = S_MEM_RD;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_MEM_RD: begin
                iord_s = 1'b1;
                if (bus.mem_ready) begin
                    next_s = S_MEM_WB;
                end else begin
                    next_s = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                rfwe_s    = 1'b1;
                m_to_rf_s = 1'b1;
                retire_s  = 1'b1;
                next_s    = S_FETCH;
            end
            S_MEM_WR: begin
                // The write strobe stays up until memory accepts it
                iord_s = 1'b1;
                dmwe_s = 1'b1;
                if (bus.mem_ready) begin
                    retire_s = 1'b1;
                    next_s   = S_FETCH;
                end else begin
                    next_s = S_MEM_WR;
                end
            end
            S_R_EXEC: begin
                sel1_s = A_REGA;
                sel2_s = B_REGB;
                next_s = S_R_WB;
                case (bus.funct)
                    FN_ADD:  alu_sel_s = ALU_ADD;
                    FN_SUB:  alu_sel_s = ALU_SUB;
                    FN_AND:  alu_sel_s = ALU_AND;
                    FN_OR:   alu_sel_s = ALU_OR;
                    FN_SLLV: alu_sel_s = ALU_SLL;
                    FN_SRAV: alu_sel_s = ALU_SRA;
                    FN_SLL: begin
                        alu_sel_s = ALU_SLL;
                        sel1_s    = A_SHAMT;
                    end
                    default: begin
                        alu_sel_s = ALU_ADD;
                        illegal_s = 1'b1;
                        next_s    = S_FETCH;
                    end
                endcase
                alu_hold_s = alu_sel_s;
            end
            S_R_WB: begin
                // Keep the ALU operation stable through the write-back cycle
                rfwe_s    = 1'b1;
                rfd_s     = 1'b1;
                alu_sel_s = alu_hold_r;
                retire_s  = 1'b1;
                next_s    = S_FETCH;
            end
            S_BRANCH: begin
                sel1_s    = A_REGA;
                sel2_s    = B_REGB;
                alu_sel_s = ALU_SUB;
                pc_src_s  = PC_OUT;
                pcwe_s    = bus.zero;
                retire_s  = 1'b1;
                next_s    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                sel1_s    = A_REGA;
                sel2_s    = B_IMM;
                alu_sel_s = ALU_ADD;
                next_s    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                rfwe_s   = 1'b1;
                retire_s = 1'b1;
                next_s   = S_FETCH;
            end
            S_JUMP: begin
                pc_src_s = PC_JUMP;
                pcwe_s   = 1'b1;
                retire_s = 1'b1;
                next_s   = S_FETCH;
            end
            default: begin
                // Unused codes recover to FETCH without side effects
                next_s = S_FETCH;
            end
        endcase
    end

    // State, held ALU operation and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_FETCH;
            count_r    <= {CNT_W{1'b0}};
            alu_hold_r <= 4'b0000;
        end else begin
            state_r    <= next_s;
            alu_hold_r <= alu_hold_s;
            if (retire_s) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign bus.PCWE        = pcwe_s & ~reset;
    assign bus.IRWE        = irwe_s & ~reset;
    assign bus.RFWE        = rfwe_s & ~reset;
    assign bus.DMWE        = dmwe_s & ~reset;
    assign bus.illegal     = illegal_s & ~reset;
    assign bus.IorD        = iord_s;
    assign bus.M_to_RF_sel = m_to_rf_s;
    assign bus.RFD_sel     = rfd_s;
    assign bus.ALU_in_sel1 = sel1_s;
    assign bus.ALU_in_sel2 = sel2_s;
    assign bus.PC_src      = pc_src_s;
    assign bus.ALU_sel     = alu_sel_s;
    assign bus.state       = state_r;
    assign bus.instr_count = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. The driver issues one cycle of
// stimulus at a time and queues the hand-derived expected outputs; a
// separate monitor pops and compares on the falling edge. A second
// instance with a 4-bit counter shares the stimulus to exercise wrap.
module tb_multicycle_control;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    logic       clk;
    logic       reset_r;
    logic [5:0] opcode_r;
    logic [5:0] funct_r;
    logic       zero_r;
    logic       mem_ready_r;
    logic [15:0] exp_cnt;
    int         n_checks;
    int         n_fails;
    exp_t       sb_q[$];

    multicycle_control_if #(.CNT_W(16)) bus ();
    multicycle_control_if #(.CNT_W(4))  bus4 ();

    assign bus.opcode     = opcode_r;
    assign bus.funct      = funct_r;
    assign bus.zero       = zero_r;
    assign bus.mem_ready  = mem_ready_r;
    assign bus4.opcode    = opcode_r;
    assign bus4.funct     = funct_r;
    assign bus4.zero      = zero_r;
    assign bus4.mem_ready = mem_ready_r;

    multicycle_control #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset_r),
        .bus   (bus.master)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset_r),
        .bus   (bus4.master)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs expected controls: PCWE IRWE RFWE DMWE IorD M2RF RFD sel1 sel2 pcsrc alu illegal.
    function automatic logic [17:0] mk(input logic pcwe, input logic irwe, input logic rfwe,
                                       input logic dmwe, input logic iord, input logic m2rf,
                                       input logic rfd, input logic [1:0] s1, input logic [1:0] s2,
                                       input logic [1:0] pcs, input logic [3:0] alu, input logic ill);
        return {pcwe, irwe, rfwe, dmwe, iord, m2rf, rfd, s1, s2, pcs, alu, ill};
    endfunction

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0000;

    // Checks the outputs of both instances against the oldest queued entry.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e = sb_q.pop_front();
            act = {bus.PCWE, bus.IRWE, bus.RFWE, bus.DMWE, bus.IorD, bus.M_to_RF_sel,
                   bus.RFD_sel, bus.ALU_in_sel1, bus.ALU_in_sel2, bus.PC_src, bus.ALU_sel,
                   bus.illegal};
            n_checks = n_checks + 4;
            if (bus.state !== e.st) begin
                n_fails = n_fails + 1;
                $display("FAIL %s state: got %0d want %0d", e.name, bus.state, e.st);
            end
            if (act !== e.ctrl) begin
                n_fails = n_fails + 1;
                $display("FAIL %s ctrl: got %b want %b", e.name, act, e.ctrl);
            end
            if (bus.instr_count !== e.cnt) begin
                n_fails = n_fails + 1;
                $display("FAIL %s count: got %0d want %0d", e.name, bus.instr_count, e.cnt);
            end
            if (bus4.instr_count !== e.cnt[3:0]) begin
                n_fails = n_fails + 1;
                $display("FAIL %s count4: got %0d want %0d", e.name, bus4.instr_count, e.cnt[3:0]);
            end
        end
    end

    task automatic step(input logic [3:0] st, input logic [17:0] ctrl, input logic z,
                        input logic mr, input logic rst, input string nm);
        exp_t e;
        zero_r      = z;
        mem_ready_r = mr;
        reset_r     = rst;
        e.st   = st;
        e.ctrl = ctrl;
        e.cnt  = exp_cnt;
        e.name = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] opc, input logic [5:0] fn, input string nm);
        opcode_r = opc;
        funct_r  = fn;
        step(4'd0, mk(1,1,0,0,0,0,0,2'b00,2'b01,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, {nm, "_fetch"});
        step(4'd1, mk(0,0,0,0,0,0,0,2'b00,2'b11,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, {nm, "_decode"});
    endtask

    task automatic do_lw(input int rd_stall);
        fetch_decode(6'b100011, 6'b000000, "lw");
        step(4'd2, mk(0,0,0,0,0,0,0,2'b01,2'b10,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, "lw_addr");
        for (int i = 0; i < rd_stall; i++)
            step(4'd3, mk(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,SUB,0), 1'b0, 1'b0, 1'b0, "lw_rd_wait");
        step(4'd3, mk(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,SUB,0), 1'b0, 1'b1, 1'b0, "lw_rd");
        step(4'd4, mk(0,0,1,0,0,1,0,2'b00,2'b00,2'b00,SUB,0), 1'b0, 1'b1, 1'b0, "lw_wb");
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_sw();
        fetch_decode(6'b101011, 6'b000000, "sw");
        step(4'd2, mk(0,0,0,0,0,0,0,2'b01,2'b10,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, "sw_addr");
        step(4'd5, mk(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,SUB,0), 1'b0, 1'b1, 1'b0, "sw_wr");
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_rtype(input logic [5:0] fn, input logic [3:0] alu, input logic [1:0] s1);
        fetch_decode(6'b000000, fn, "rtype");
        step(4'd6, mk(0,0,0,0,0,0,0,s1,2'b00,2'b00,alu,0), 1'b0, 1'b1, 1'b0, "r_exec");
        step(4'd7, mk(0,0,1,0,0,0,1,2'b00,2'b00,2'b00,alu,0), 1'b0, 1'b1, 1'b0, "r_wb");
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_beq(input logic z);
        fetch_decode(6'b000100, 6'b000000, "beq");
        step(4'd8, mk(z,0,0,0,0,0,0,2'b01,2'b00,2'b01,SUB,0), z, 1'b1, 1'b0, "beq_branch");
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_addi();
        fetch_decode(6'b001000, 6'b000000, "addi");
        step(4'd9, mk(0,0,0,0,0,0,0,2'b01,2'b10,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, "addi_exec");
        step(4'd10, mk(0,0,1,0,0,0,0,2'b00,2'b00,2'b00,SUB,0), 1'b0, 1'b1, 1'b0, "addi_wb");
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_jump_stalled();
        opcode_r = 6'b000010;
        funct_r  = 6'b000000;
        for (int i = 0; i < 3; i++)
            step(4'd0, mk(0,0,0,0,0,0,0,2'b00,2'b01,2'b00,ADD,0), 1'b0, 1'b0, 1'b0, "fetch_stall");
        step(4'd0, mk(1,1,0,0,0,0,0,2'b00,2'b01,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, "fetch_go");
        step(4'd1, mk(0,0,0,0,0,0,0,2'b00,2'b11,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, "j_decode");
        step(4'd11, mk(1,0,0,0,0,0,0,2'b00,2'b00,2'b10,SUB,0), 1'b0, 1'b1, 1'b0, "j_jump");
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_bad_opcode();
        opcode_r = 6'b111111;
        funct_r  = 6'b000000;
        step(4'd0, mk(1,1,0,0,0,0,0,2'b00,2'b01,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, "badop_fetch");
        step(4'd1, mk(0,0,0,0,0,0,0,2'b00,2'b11,2'b00,ADD,1), 1'b0, 1'b1, 1'b0, "badop_decode");
    endtask

    task automatic do_bad_funct();
        fetch_decode(6'b000000, 6'b101010, "badfn");
        step(4'd6, mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,ADD,1), 1'b0, 1'b1, 1'b0, "badfn_exec");
    endtask

    task automatic do_sw_reset();
        fetch_decode(6'b101011, 6'b000000, "swrst");
        step(4'd2, mk(0,0,0,0,0,0,0,2'b01,2'b10,2'b00,ADD,0), 1'b0, 1'b1, 1'b0, "swrst_addr");
        step(4'd5, mk(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,SUB,0), 1'b0, 1'b0, 1'b0, "swrst_wait");
        step(4'd5, mk(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,SUB,0), 1'b0, 1'b0, 1'b1, "swrst_reset");
        exp_cnt = 16'd0;
    endtask

    // Directed stimulus sequence.
    initial begin
        n_checks    = 0;
        n_fails     = 0;
        exp_cnt     = 16'd0;
        reset_r     = 1'b1;
        opcode_r    = 6'b000000;
        funct_r     = 6'b000000;
        zero_r      = 1'b0;
        mem_ready_r = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_r = 1'b0;

        do_lw(0);
        do_lw(2);
        do_jump_stalled();
        do_sw();
        do_rtype(6'b100000, 4'b0010, 2'b01);
        do_rtype(6'b100010, 4'b0000, 2'b01);
        do_rtype(6'b100100, 4'b1000, 2'b01);
        do_rtype(6'b100101, 4'b1001, 2'b01);
        do_rtype(6'b000100, 4'b0011, 2'b01);
        do_rtype(6'b000111, 4'b0111, 2'b01);
        do_rtype(6'b000000, 4'b0011, 2'b10);
        do_beq(1'b1);
        do_beq(1'b0);
        do_addi();
        do_bad_opcode();
        do_bad_funct();
        do_sw_reset();
        for (int k = 0; k < 16; k++)
            do_addi();
        opcode_r = 6'b000000;
        step(4'd0, mk(0,0,0,0,0,0,0,2'b00,2'b01,2'b00,ADD,0), 1'b0, 1'b0, 1'b0, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port opcode, input, 6, instruction[31:26], stable from the cycle after fetch completes.
REQ-005 SHALL have port funct, input, 6, instruction[5:0].
REQ-006 SHALL have port zero, input, 1, ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1, memory handshake: access completes in a cycle where it is 1.
REQ-008 SHALL have outputs PCWE, IRWE, RFWE, DMWE, 1 each: PC, IR, register-file and data-memory write enables.
REQ-009 SHALL have outputs IorD, M_to_RF_sel, RFD_sel, 1 each: memory address source (0 PC, 1 ALUOut), RF write data (1 memory), RF dest (1 rd, 0 rt).
REQ-010 SHALL have outputs ALU_in_sel1 (2: 00 PC, 01 regA, 10 shamt), ALU_in_sel2 (2: 00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2), PC_src (2: 00 ALU, 01 ALUOut, 10 jump target).
REQ-011 SHALL have output ALU_sel, 4: ADD 0010, SUB 0000, SLL 0011, SRA 0111, AND 1000, OR 1001.
REQ-012 SHALL have outputs state (4, current state code), illegal (1, one-cycle pulse), instr_count (CNT_W, retired instructions).

Function
REQ-013 SHALL be a registered Moore-style FSM; outputs decode combinationally from state, opcode, funct, zero, mem_ready; unlisted strobes 0, unlisted selects 0.
REQ-014 SHALL encode states FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, ADDI_EXEC 9, ADDI_WB 10, JUMP 11; codes 12-15 go to FETCH next cycle.
REQ-015 FETCH: IorD 0, ALU_in_sel1 00, ALU_in_sel2 01, ADD, PC_src 00; IRWE=PCWE=mem_ready; stay while mem_ready 0, go DECODE when 1.
REQ-016 DECODE: ALU_in_sel1 00, ALU_in_sel2 11, ADD (branch target); next: LW 100011/SW 101011 -> MEM_ADDR, 000000 -> R_EXEC, BEQ 000100 -> BRANCH, ADDI 001000 -> ADDI_EXEC, J 000010 -> JUMP, else -> FETCH with illegal=1 this cycle.
REQ-017 MEM_ADDR: ALU_in_sel1 01, ALU_in_sel2 10, ADD; next MEM_RD for LW, MEM_WR for SW.
REQ-018 MEM_RD: IorD 1; stay until mem_ready 1, then MEM_WB.
REQ-019 MEM_WB: RFWE 1, RFD_sel 0, M_to_RF_sel 1; next FETCH.
REQ-020 MEM_WR: IorD 1, DMWE 1 held every cycle in state; leave to FETCH in the cycle mem_ready is 1.
REQ-021 R_EXEC: ALU_in_sel1 01, ALU_in_sel2 00; funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 000100 SLL, 000111 SRA, 000000 SLL with ALU_in_sel1 10; next R_WB; any other funct: ALU_sel ADD, illegal=1, next FETCH, no RF write.
REQ-022 R_WB: RFWE 1, RFD_sel 1, M_to_RF_sel 0, ALU_sel held from R_EXEC decode; next FETCH.
REQ-023 BRANCH: ALU_in_sel1 01, ALU_in_sel2 00, SUB, PC_src 01, PCWE=zero; next FETCH.
REQ-024 ADDI_EXEC: ALU_in_sel1 01, ALU_in_sel2 10, ADD; next ADDI_WB. ADDI_WB: RFWE 1, RFD_sel 0, M_to_RF_sel 0; next FETCH.
REQ-025 JUMP: PC_src 10, PCWE 1; next FETCH.
REQ-026 instr_count SHALL increment by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, ADDI_WB, JUMP; never on illegal exits; wraps 2^CNT_W-1 -> 0.
REQ-027 Latency with mem_ready tied 1: LW 5 cycles, SW/R/ADDI 4, BEQ/J 3.

Reset
REQ-028 reset high at a clock edge SHALL set state FETCH, instr_count 0; illegal 0 next cycle.
REQ-029 While reset is high, PCWE, IRWE, RFWE, DMWE SHALL be forced 0 regardless of state or mem_ready.
REQ-030 Reset mid-instruction (any state incl. MEM_WR) SHALL abandon it: no further write strobes, no count increment, FETCH after release.

Verification
REQ-031 LW, mem_ready=1: states 0,1,2,3,4,0; RFWE=1 only in state 4 with M_to_RF_sel 1; instr_count 0->1.
REQ-032 Fetch stall: mem_ready 0 for 3 cycles in FETCH -> state stays 0, IRWE=PCWE=0; 4th cycle mem_ready 1 -> IRWE=PCWE=1, next state 1.
REQ-033 BEQ zero=1 -> PCWE 1, PC_src 01 in state 8; zero=0 -> PCWE 0; both count +1.
REQ-034 opcode 111111 -> illegal=1 in DECODE, next FETCH, count unchanged; R-type funct 101010 -> illegal in R_EXEC, RFWE never 1.
REQ-035 SW with mem_ready 0 two cycles in MEM_WR, reset asserted on 2nd -> DMWE 0 in reset cycle, state 0, count 0.
REQ-036 CNT_W=4, 16 retired ADDIs -> instr_count wraps 15 -> 0.
